// File: rtl/alu_issue_capture.sv
// rtl/alu_issue_capture.sv - ALU operand issue, opcode-dependent settle wait and 64-bit Z capture with valid/ready
// Optional feature macro: ALU_ISSUE_FLAGS_EN adds registered z_zero / z_neg result flags.
module alu_issue_capture #(
    parameter int unsigned SIMPLE_WAIT = 1,
    parameter int unsigned MULDIV_WAIT = 6,
    parameter int unsigned CNT_W       = 4
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] y_in,
    input  logic [31:0] b_in,
    input  logic [4:0]  op_in,
    output logic        busy,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_op,
    input  logic [63:0] alu_c,
    output logic [31:0] z_low,
    output logic [31:0] z_high,
    output logic        z_valid,
    input  logic        z_ready,
`ifdef ALU_ISSUE_FLAGS_EN
    output logic        z_zero,
    output logic        z_neg,
`endif
    output logic        illegal_op
);

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_DIV = 5'b01111;
    localparam logic [4:0] OP_MUL = 5'b10000;
    localparam logic [4:0] OP_MAX = 5'b10011;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_CAPTURE = 2'd2,
        S_PRESENT = 2'd3
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic [31:0]        r_alu_a;
    logic [31:0]        r_alu_b;
    logic [4:0]         r_alu_op;
    logic [31:0]        r_z_low;
    logic [31:0]        r_z_high;
    logic               r_z_valid;
    logic               r_illegal;

    // Settle time is chosen from the incoming opcode at issue; mul/div need the long wait.
    logic               w_in_muldiv;
    assign w_in_muldiv = (op_in == OP_MUL) || (op_in == OP_DIV);

`ifdef ALU_ISSUE_FLAGS_EN
    logic               r_z_zero;
    logic               r_z_neg;
    logic               w_held_muldiv;
    logic               w_flag_zero;
    logic               w_flag_neg;

    // Mul/div produce a full 64-bit result, so zero covers all of C; sign comes from the
    // product MSB for Multiply and from the quotient MSB for Divide.
    assign w_held_muldiv = (r_alu_op == OP_MUL) || (r_alu_op == OP_DIV);
    assign w_flag_zero   = w_held_muldiv ? (alu_c == 64'd0) : (alu_c[31:0] == 32'd0);
    assign w_flag_neg    = (r_alu_op == OP_MUL) ? alu_c[63] : alu_c[31];

    assign z_zero = r_z_zero;
    assign z_neg  = r_z_neg;
`endif

    // Issue/settle/capture/present sequencer with all outputs registered.
    always_ff @(posedge clock) begin
        if (!clear) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_alu_a   <= 32'd0;
            r_alu_b   <= 32'd0;
            r_alu_op  <= OP_ADD;
            r_z_low   <= 32'd0;
            r_z_high  <= 32'd0;
            r_z_valid <= 1'b0;
            r_illegal <= 1'b0;
`ifdef ALU_ISSUE_FLAGS_EN
            r_z_zero  <= 1'b0;
            r_z_neg   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_alu_a   <= y_in;
                        r_alu_b   <= b_in;
                        r_alu_op  <= op_in;
                        r_cnt     <= w_in_muldiv ? CNT_W'(MULDIV_WAIT) : CNT_W'(SIMPLE_WAIT);
                        r_illegal <= (op_in > OP_MAX);
                        r_busy    <= 1'b1;
                        r_state   <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    // An illegal opcode still captures whatever C the ALU is holding.
                    r_z_low   <= alu_c[31:0];
                    r_z_high  <= alu_c[63:32];
                    r_z_valid <= 1'b1;
`ifdef ALU_ISSUE_FLAGS_EN
                    r_z_zero  <= w_flag_zero;
                    r_z_neg   <= w_flag_neg;
`endif
                    r_state   <= S_PRESENT;
                end
                S_PRESENT: begin
                    // start in the acceptance cycle is dropped: it is only sampled in IDLE.
                    if (z_ready) begin
                        r_z_valid <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_op     = r_alu_op;
    assign z_low      = r_z_low;
    assign z_high     = r_z_high;
    assign z_valid    = r_z_valid;
    assign illegal_op = r_illegal;

endmodule
